// File: rtl/logic_unit_pkg.sv
// Shared encodings for the iterative bitwise logic unit.
// Operation codes, FSM states and the slice-counter width helper.
package logic_unit_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // A single-slice unit still needs a 1-bit counter to keep the datapath uniform.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/logic_unit_iter_if.sv
// Operand (valid/ready in) and result (valid/ready out) bundle of the logic unit.
// master = operand producer / result consumer, slave = the unit itself.
interface logic_unit_iter_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             zero;

    modport master (
        output in_valid, op, A, B, out_ready,
        input  in_ready, out_valid, res, zero
    );

    modport slave (
        input  in_valid, op, A, B, out_ready,
        output in_ready, out_valid, res, zero
    );
endinterface

// File: rtl/logic_slice.sv
// One CHUNK-bit slice of the bitwise function; purely combinational, no state.
// No inter-slice carries, so slices can be evaluated in any order.
module logic_slice
    import logic_unit_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  op_e              op,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic [CHUNK-1:0] y
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOR: y = ~(a | b);
        endcase
    end

endmodule

// File: rtl/logic_unit_iter.sv
// Iterative AND/OR/XOR/NOR unit, one CHUNK slice per clock; result valid WIDTH/CHUNK cycles after accept.
// Holds the result in DONE indefinitely while out_ready is low; accepts operands only in IDLE.
module logic_unit_iter
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    logic_unit_iter_if.slave  bus
);

    localparam int            N    = WIDTH / CHUNK;
    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (CHUNK <= 0 || WIDTH % CHUNK != 0) begin : g_chunk_check
            $error("logic_unit_iter: CHUNK must be positive and divide WIDTH");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;

    logic [31:0]      shamt;
    logic [CHUNK-1:0] slice_a, slice_b, slice_y;

    // Single shared slice evaluator fed by the counter-indexed operand mux.
    assign shamt   = 32'(cnt_q) * 32'(CHUNK);
    assign slice_a = CHUNK'(a_q >> shamt);
    assign slice_b = CHUNK'(b_q >> shamt);

    logic_slice #(.CHUNK(CHUNK)) u_slice (
        .op (op_q),
        .a  (slice_a),
        .b  (slice_b),
        .y  (slice_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_AND;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        zero_d  = zero_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    op_d    = op_e'(bus.op);
                    res_d   = '0;
                    zero_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // res was cleared on accept, so OR-ing the shifted slice writes it in place.
                res_d  = res_q | (WIDTH'(slice_y) << shamt);
                zero_d = zero_q & (slice_y == '0);
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
        bus.res       = res_q;
        bus.zero      = zero_q;
    end

endmodule

// File: tb/tb_logic_unit_iter.sv
// Drives three configurations (32/8, 32/32, 16/4) from a vector table, directed corner sequences
// and random traffic; results are scored against a full-width reference model via per-unit queues.
module tb_logic_unit_iter;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
    } exp_t;

    typedef struct {
        int          unit;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_v  [3];
    logic [1:0]  op_v        [3];
    logic [31:0] a_v         [3];
    logic [31:0] b_v         [3];
    logic        out_ready_v [3];
    logic        in_ready_w  [3];
    logic        out_valid_w [3];
    logic        zero_w      [3];
    logic [31:0] res_w       [3];

    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    vec_t tbl[8];

    always #5 clk = ~clk;

    logic_unit_iter_if #(.WIDTH(32)) if0 ();
    logic_unit_iter_if #(.WIDTH(32)) if1 ();
    logic_unit_iter_if #(.WIDTH(16)) if2 ();

    logic_unit_iter #(.WIDTH(32), .CHUNK(8))  u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    logic_unit_iter #(.WIDTH(32), .CHUNK(32)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    logic_unit_iter #(.WIDTH(16), .CHUNK(4))  u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    assign if0.in_valid = in_valid_v[0];
    assign if0.op       = op_v[0];
    assign if0.A        = a_v[0];
    assign if0.B        = b_v[0];
    assign if0.out_ready = out_ready_v[0];
    assign in_ready_w[0]  = if0.in_ready;
    assign out_valid_w[0] = if0.out_valid;
    assign res_w[0]       = if0.res;
    assign zero_w[0]      = if0.zero;

    assign if1.in_valid = in_valid_v[1];
    assign if1.op       = op_v[1];
    assign if1.A        = a_v[1];
    assign if1.B        = b_v[1];
    assign if1.out_ready = out_ready_v[1];
    assign in_ready_w[1]  = if1.in_ready;
    assign out_valid_w[1] = if1.out_valid;
    assign res_w[1]       = if1.res;
    assign zero_w[1]      = if1.zero;

    assign if2.in_valid = in_valid_v[2];
    assign if2.op       = op_v[2];
    assign if2.A        = a_v[2][15:0];
    assign if2.B        = b_v[2][15:0];
    assign if2.out_ready = out_ready_v[2];
    assign in_ready_w[2]  = if2.in_ready;
    assign out_valid_w[2] = if2.out_valid;
    assign res_w[2]       = {16'h0000, if2.res};
    assign zero_w[2]      = if2.zero;

    function automatic int uw(input int u);
        return (u == 2) ? 16 : 32;
    endfunction

    function automatic int un(input int u);
        return (u == 1) ? 1 : 4;
    endfunction

    function automatic exp_t model(input int u, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] r;
        logic [31:0] m;
        m = (uw(u) == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = ~(a | b);
        endcase
        r      = r & m;
        e.res  = r;
        e.zero = (r == 32'd0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_push(input int u, input exp_t e);
        case (u)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int sb_size(input int u);
        case (u)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t sb_pop(input int u);
        case (u)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Scoreboard: a handshake is visible here (negedge) before the edge that completes it.
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (rst_n && out_valid_w[u] && out_ready_v[u]) begin
                if (sb_size(u) == 0) begin
                    chk($sformatf("sb_unexpected_u%0d", u), 32'(out_valid_w[u]), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_pop(u);
                    chk($sformatf("sb_res_u%0d", u), res_w[u], e.res);
                    chk($sformatf("sb_zero_u%0d", u), 32'(zero_w[u]), 32'(e.zero));
                end
            end
        end
    end

    task automatic issue(input int u, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int t;
        t = 0;
        @(posedge clk); #1;
        while (!in_ready_w[u] && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready_w[u]) begin
            chk($sformatf("issue_wait_u%0d", u), 32'(in_ready_w[u]), 32'd1);
            return;
        end
        in_valid_v[u] = 1'b1;
        op_v[u]       = op;
        a_v[u]        = a;
        b_v[u]        = b;
        @(posedge clk);
        sb_push(u, model(u, op, a, b));
        #1;
        // Operands become don't-care once accepted; scramble them.
        in_valid_v[u] = 1'b0;
        op_v[u]       = 2'($urandom);
        a_v[u]        = $urandom;
        b_v[u]        = $urandom;
    endtask

    task automatic wait_valid(input int u, output int lat);
        lat = 0;
        while (!out_valid_w[u] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        issue(v.unit, v.op, v.a, v.b);
        wait_valid(v.unit, lat);
        chk($sformatf("latency_u%0d", v.unit), 32'(lat), 32'(un(v.unit)));
        chk($sformatf("vec_res_u%0d", v.unit), res_w[v.unit], v.res);
        chk($sformatf("vec_zero_u%0d", v.unit), 32'(zero_w[v.unit]), 32'(v.zero));
        @(posedge clk); #1;
        chk($sformatf("valid_pulse_u%0d", v.unit), 32'(out_valid_w[v.unit]), 32'd0);
        chk($sformatf("ready_after_u%0d", v.unit), 32'(in_ready_w[v.unit]), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        logic seen;
        logic rnd_on;

        for (int u = 0; u < 3; u++) begin
            in_valid_v[u]  = 1'b0;
            op_v[u]        = 2'b00;
            a_v[u]         = 32'd0;
            b_v[u]         = 32'd0;
            out_ready_v[u] = 1'b1;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("rst_in_ready_u%0d", u), 32'(in_ready_w[u]), 32'd1);
            chk($sformatf("rst_out_valid_u%0d", u), 32'(out_valid_w[u]), 32'd0);
            chk($sformatf("rst_res_u%0d", u), res_w[u], 32'd0);
            chk($sformatf("rst_zero_u%0d", u), 32'(zero_w[u]), 32'd0);
        end
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;

        tbl[0] = '{0, 2'b01, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b0};
        tbl[1] = '{0, 2'b00, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_0000, 1'b1};
        tbl[2] = '{0, 2'b10, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1};
        tbl[3] = '{0, 2'b11, 32'h0000_0000, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0};
        tbl[4] = '{1, 2'b10, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b0};
        tbl[5] = '{1, 2'b01, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
        tbl[6] = '{2, 2'b11, 32'h0000_00FF, 32'h0000_0F00, 32'h0000_F000, 1'b0};
        tbl[7] = '{2, 2'b00, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_0000, 1'b1};
        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i]);
        end

        // Backpressure: result must hold while the consumer stalls and new operands knock.
        out_ready_v[0] = 1'b0;
        issue(0, 2'b01, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
        wait_valid(0, lat);
        chk("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid_v[0] = ~in_valid_v[0];
            a_v[0]        = $urandom;
            b_v[0]        = $urandom;
            op_v[0]       = 2'($urandom);
            chk("bp_res", res_w[0], 32'hFFFF_FFFF);
            chk("bp_out_valid", 32'(out_valid_w[0]), 32'd1);
            chk("bp_in_ready", 32'(in_ready_w[0]), 32'd0);
        end
        @(posedge clk); #1;
        in_valid_v[0]  = 1'b0;
        out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", 32'(in_ready_w[0]), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid_w[0]), 32'd0);

        // Reset in the middle of RUN discards the operation.
        issue(0, 2'b10, 32'hDEAD_BEEF, 32'h0F0F_0F0F);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        void'(q0.pop_back());
        chk("midrst_in_ready", 32'(in_ready_w[0]), 32'd1);
        chk("midrst_out_valid", 32'(out_valid_w[0]), 32'd0);
        chk("midrst_res", res_w[0], 32'd0);
        chk("midrst_zero", 32'(zero_w[0]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid_w[0];
        end
        chk("midrst_no_valid", 32'(seen), 32'd0);
        run_vec(tbl[3]);

        // Random traffic on all three configurations with consumer stalls.
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    for (int u = 0; u < 3; u++) begin
                        out_ready_v[u] = ($urandom_range(0, 3) != 0);
                    end
                end
            end
        join_none
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    issue(0, 2'($urandom), $urandom, $urandom);
                end
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    issue(1, 2'($urandom), $urandom, $urandom);
                end
            end
            begin
                for (int j = 0; j < 1000; j++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    issue(2, 2'($urandom), $urandom, $urandom);
                end
            end
        join
        for (int t = 0; t < 500; t++) begin
            if (sb_size(0) + sb_size(1) + sb_size(2) == 0) break;
            @(posedge clk); #1;
        end
        rnd_on = 1'b0;
        @(posedge clk); #1;
        for (int u = 0; u < 3; u++) begin
            out_ready_v[u] = 1'b1;
        end
        @(posedge clk); #1;
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("sb_drained_u%0d", u), 32'(sb_size(u)), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
